// File: rtl/mem_spi_arbiter_if.sv
// rtl/mem_spi_arbiter_if.sv - requester-side and controller-side signals of the SPI arbiter
interface mem_spi_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   in_req;
  logic [NUM_REQ-1:0]   in_rw;
  logic [NUM_REQ-1:0]   in_tx_valid;
  logic [8*NUM_REQ-1:0] in_tx_data;
  logic [NUM_REQ-1:0]   in_rx_ready;
  logic [NUM_REQ-1:0]   out_gnt;
  logic [NUM_REQ-1:0]   out_tx_ready;
  logic [NUM_REQ-1:0]   out_rx_valid;
  logic [7:0]           out_rx_data;
  logic [NUM_REQ-1:0]   out_done;
  logic                 out_timeout;
  logic                 out_spi_start;
  logic                 out_spi_r_w;
  logic                 out_spi_tx_valid;
  logic [7:0]           out_spi_tx_data;
  logic                 out_spi_rx_ready;
  logic                 in_spi_tx_ready;
  logic                 in_spi_rx_valid;
  logic [7:0]           in_spi_rx_data;
  logic                 in_spi_done;

  modport slave (
    input  in_req, in_rw, in_tx_valid, in_tx_data, in_rx_ready,
    input  in_spi_tx_ready, in_spi_rx_valid, in_spi_rx_data, in_spi_done,
    output out_gnt, out_tx_ready, out_rx_valid, out_rx_data, out_done, out_timeout,
    output out_spi_start, out_spi_r_w, out_spi_tx_valid, out_spi_tx_data, out_spi_rx_ready
  );

  modport master (
    output in_req, in_rw, in_tx_valid, in_tx_data, in_rx_ready,
    output in_spi_tx_ready, in_spi_rx_valid, in_spi_rx_data, in_spi_done,
    input  out_gnt, out_tx_ready, out_rx_valid, out_rx_data, out_done, out_timeout,
    input  out_spi_start, out_spi_r_w, out_spi_tx_valid, out_spi_tx_data, out_spi_rx_ready
  );
endinterface

// File: rtl/mem_spi_arbiter.sv
// rtl/mem_spi_arbiter.sv - round-robin owner of the shared SPI controller, held per transaction
module mem_spi_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  mem_spi_arbiter_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int WD_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt, gnt_nxt;
  logic [IDX_W-1:0]   last_idx, last_nxt;
  logic               r_w, rw_nxt;
  logic [WD_W-1:0]    wd_cnt, wd_nxt;
  logic               timeout, tmo_nxt;

  logic [IDX_W-1:0]   cand, win_idx;
  logic               win_found;

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_idx;
    cand      = last_idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDX_MAX) ? '0 : cand + IDX_W'(1);
      if (!win_found && bus.in_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      last_idx <= IDX_MAX;
      r_w      <= 1'b0;
      wd_cnt   <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_idx <= last_nxt;
      r_w      <= rw_nxt;
      wd_cnt   <= wd_nxt;
      timeout  <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last_idx;
    rw_nxt    = r_w;
    wd_nxt    = wd_cnt;
    tmo_nxt   = timeout;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = START;
          gnt_nxt   = NUM_REQ'(1) << win_idx;
          last_nxt  = win_idx;
          rw_nxt    = bus.in_rw[win_idx];
          wd_nxt    = '0;
        end
      end
      START: begin
        if (bus.in_spi_done) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
        end else begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.in_spi_done) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
        end else if (TIMEOUT_CYC != 0 && wd_cnt == WD_LAST) begin
          state_nxt = GAP;
          gnt_nxt   = '0;
          tmo_nxt   = 1'b1;
        end else begin
          wd_nxt = wd_cnt + WD_W'(1);
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  logic       active;
  logic       sel_txv, sel_rxr;
  logic [7:0] sel_txd;

  assign active = (state == START) || (state == BUSY);

  // gnt is one-hot, so OR-ing the gated lanes acts as the owner mux.
  always_comb begin
    sel_txv = 1'b0;
    sel_rxr = 1'b0;
    sel_txd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_txv = sel_txv | bus.in_tx_valid[i];
        sel_rxr = sel_rxr | bus.in_rx_ready[i];
        sel_txd = sel_txd | bus.in_tx_data[8*i +: 8];
      end
    end
  end

  assign bus.out_gnt          = gnt;
  assign bus.out_spi_start    = (state == START);
  assign bus.out_spi_r_w      = r_w;
  assign bus.out_timeout      = timeout;
  assign bus.out_spi_tx_valid = active & sel_txv;
  assign bus.out_spi_tx_data  = active ? sel_txd : 8'h00;
  assign bus.out_spi_rx_ready = active & sel_rxr;
  assign bus.out_rx_data      = active ? bus.in_spi_rx_data : 8'h00;
  assign bus.out_tx_ready     = {NUM_REQ{active & bus.in_spi_tx_ready}} & gnt;
  assign bus.out_rx_valid     = {NUM_REQ{active & bus.in_spi_rx_valid}} & gnt;
  assign bus.out_done         = {NUM_REQ{active & bus.in_spi_done}} & gnt;
endmodule

// File: tb/tb_mem_spi_arbiter.sv
// tb/tb_mem_spi_arbiter.sv - directed and random checks of mem_spi_arbiter against a transaction model
module tb_mem_spi_arbiter;
  localparam int NR  = 2;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_spi_arbiter_if #(.NUM_REQ(NR)) bus ();

  mem_spi_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model: who owns the controller, how long they have held it.
  int m_owner = -1;
  int m_age   = 0;
  int m_last  = NR - 1;
  bit m_gap   = 1'b0;
  bit m_rw    = 1'b0;
  bit m_tmo   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_owner = -1; m_age = 0; m_last = NR - 1; m_gap = 1'b0; m_rw = 1'b0; m_tmo = 1'b0;
    end else if (m_owner >= 0) begin
      if (bus.in_spi_done) begin
        m_owner = -1; m_gap = 1'b1;
      end else if (m_age == TMO) begin
        m_tmo = 1'b1; m_owner = -1; m_gap = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (m_owner < 0 && bus.in_req[c]) begin
          m_owner = c; m_age = 0; m_last = c; m_rw = bus.in_rw[c];
        end
      end
    end
  endtask

  task automatic model_check();
    bit         act;
    logic [1:0] eg;
    logic [7:0] etxd;
    bit         etxv, erxr;
    act  = (m_owner >= 0);
    eg   = act ? 2'(1 << m_owner) : 2'b00;
    etxd = 8'h00; etxv = 1'b0; erxr = 1'b0;
    if (act) begin
      etxd = bus.in_tx_data[8*m_owner +: 8];
      etxv = bus.in_tx_valid[m_owner];
      erxr = bus.in_rx_ready[m_owner];
    end
    chk("gnt",         bus.out_gnt,          eg);
    chk("spi_start",   bus.out_spi_start,    act && m_age == 0);
    chk("spi_r_w",     bus.out_spi_r_w,      m_rw);
    chk("timeout",     bus.out_timeout,      m_tmo);
    chk("spi_tx_valid",bus.out_spi_tx_valid, etxv);
    chk("spi_tx_data", bus.out_spi_tx_data,  etxd);
    chk("spi_rx_ready",bus.out_spi_rx_ready, erxr);
    chk("rx_data",     bus.out_rx_data,      act ? bus.in_spi_rx_data : 8'h00);
    chk("tx_ready",    bus.out_tx_ready,     (act && bus.in_spi_tx_ready) ? eg : 2'b00);
    chk("rx_valid",    bus.out_rx_valid,     (act && bus.in_spi_rx_valid) ? eg : 2'b00);
    chk("done",        bus.out_done,         (act && bus.in_spi_done) ? eg : 2'b00);
  endtask

  // One clock: advance the model on the edge, drive new inputs at negedge, compare 1ns later.
  task automatic apply(input bit r, input logic [1:0] req, input logic [1:0] rw,
                       input logic [1:0] txv, input logic [15:0] txd, input logic [1:0] rxr,
                       input bit stx, input bit srx, input logic [7:0] srxd, input bit dn);
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst = r;
    bus.in_req = req; bus.in_rw = rw; bus.in_tx_valid = txv; bus.in_tx_data = txd;
    bus.in_rx_ready = rxr; bus.in_spi_tx_ready = stx; bus.in_spi_rx_valid = srx;
    bus.in_spi_rx_data = srxd; bus.in_spi_done = dn;
    #1;
    model_check();
  endtask

  task automatic idle(input logic [1:0] req, input logic [1:0] rw, input bit dn);
    apply(1'b0, req, rw, 2'b00, 16'h0000, 2'b00, 1'b0, 1'b0, 8'h00, dn);
  endtask

  task automatic wait_start(input logic [1:0] req, input logic [1:0] rw);
    idle(req, rw, 1'b0);
    for (int i = 0; i < 10 && !bus.out_spi_start; i++) idle(req, rw, 1'b0);
    chk("wait_start", bus.out_spi_start, 1'b1);
  endtask

  initial begin
    int gcyc;
    bit saw_done;
    bus.in_req = '0; bus.in_rw = '0; bus.in_tx_valid = '0; bus.in_tx_data = '0;
    bus.in_rx_ready = '0; bus.in_spi_tx_ready = 1'b0; bus.in_spi_rx_valid = 1'b0;
    bus.in_spi_rx_data = '0; bus.in_spi_done = 1'b0;

    apply(1'b1, 2'b00, 2'b00, 2'b00, 16'h0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    apply(1'b1, 2'b00, 2'b00, 2'b00, 16'h0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_gnt", bus.out_gnt, 2'b00);
    chk("rst_timeout", bus.out_timeout, 1'b0);
    chk("rst_r_w", bus.out_spi_r_w, 1'b0);

    // Single request, done in cycle 5
    idle(2'b01, 2'b00, 1'b0);
    chk("t1_c0_gnt", bus.out_gnt, 2'b00);
    idle(2'b01, 2'b00, 1'b0);
    chk("t1_c1_gnt", bus.out_gnt, 2'b01);
    chk("t1_c1_start", bus.out_spi_start, 1'b1);
    idle(2'b00, 2'b00, 1'b0);
    chk("t1_c2_start", bus.out_spi_start, 1'b0);
    idle(2'b00, 2'b00, 1'b0);
    idle(2'b00, 2'b00, 1'b0);
    chk("t1_c4_gnt", bus.out_gnt, 2'b01);
    idle(2'b00, 2'b00, 1'b1);
    chk("t1_c5_done", bus.out_done, 2'b01);
    idle(2'b00, 2'b00, 1'b0);
    chk("t1_c6_gnt", bus.out_gnt, 2'b00);
    idle(2'b00, 2'b00, 1'b0);

    // Contention: requester 0 was last, so 1 wins first, then alternation
    for (int n = 0; n < 4; n++) begin
      wait_start(2'b11, 2'b00);
      chk("t2_grant", bus.out_gnt, (n % 2 == 0) ? 2'b10 : 2'b01);
      idle(2'b11, 2'b00, 1'b1);
      idle(2'b11, 2'b00, 1'b0);
      chk("t2_gap", bus.out_gnt, 2'b00);
    end
    idle(2'b00, 2'b00, 1'b0);

    // Routing for owner 1
    wait_start(2'b10, 2'b00);
    apply(1'b0, 2'b00, 2'b00, 2'b10, 16'hA55A, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("t3_txdata", bus.out_spi_tx_data, 8'hA5);
    chk("t3_txvalid", bus.out_spi_tx_valid, 1'b1);
    chk("t3_txready", bus.out_tx_ready, 2'b10);
    apply(1'b0, 2'b00, 2'b00, 2'b10, 16'hA55A, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t3_txready_lo", bus.out_tx_ready, 2'b00);
    idle(2'b00, 2'b00, 1'b1);
    idle(2'b00, 2'b00, 1'b0);

    // Direction latched at grant
    wait_start(2'b01, 2'b01);
    chk("t4_rw_start", bus.out_spi_r_w, 1'b1);
    idle(2'b00, 2'b00, 1'b0);
    idle(2'b00, 2'b00, 1'b0);
    chk("t4_rw_busy", bus.out_spi_r_w, 1'b1);
    idle(2'b00, 2'b00, 1'b1);
    idle(2'b00, 2'b00, 1'b0);
    chk("t4_rw_gap", bus.out_spi_r_w, 1'b1);

    // Watchdog: START plus 16 BUSY cycles, then forced release
    wait_start(2'b01, 2'b00);
    gcyc = 1;
    saw_done = 1'b0;
    for (int i = 0; i < 40 && bus.out_gnt != 2'b00; i++) begin
      idle(2'b00, 2'b00, 1'b0);
      if (bus.out_done != 2'b00) saw_done = 1'b1;
      if (bus.out_gnt != 2'b00) gcyc++;
    end
    chk("t5_gnt_cycles", gcyc, 17);
    chk("t5_timeout", bus.out_timeout, 1'b1);
    chk("t5_no_done", saw_done, 1'b0);
    wait_start(2'b10, 2'b00);
    chk("t5_regrant", bus.out_gnt, 2'b10);
    idle(2'b00, 2'b00, 1'b1);
    idle(2'b00, 2'b00, 1'b0);

    // Reset mid-BUSY
    wait_start(2'b01, 2'b01);
    idle(2'b00, 2'b00, 1'b0);
    apply(1'b1, 2'b11, 2'b00, 2'b00, 16'h0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
    idle(2'b11, 2'b00, 1'b0);
    chk("t6_gnt", bus.out_gnt, 2'b00);
    chk("t6_timeout", bus.out_timeout, 1'b0);
    chk("t6_r_w", bus.out_spi_r_w, 1'b0);
    idle(2'b11, 2'b00, 1'b0);
    chk("t6_first", bus.out_gnt, 2'b01);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      apply(($urandom_range(0, 299) == 0), 2'($urandom), 2'($urandom), 2'($urandom),
            16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
            ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
